// File: rtl/signed_div_pkg.sv
// -----------------------------------------------------------------------------
// signed_div_pkg
// Shared constants and types for the signed_divider block.
//   DIVIDEND_W / DIVISOR_W : operand widths (quotient/remainder are DIVISOR_W)
//   Q_MAX / Q_MIN          : saturation values for the signed quotient
//   state_t                : controller states
// -----------------------------------------------------------------------------
package signed_div_pkg;

    localparam int DIVIDEND_W = 32;
    localparam int DIVISOR_W  = 16;

    localparam logic [DIVISOR_W-1:0] Q_MAX = 16'h7FFF;
    localparam logic [DIVISOR_W-1:0] Q_MIN = 16'h8000;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        SIGN
    } state_t;

endpackage

// File: rtl/signed_divider_if.sv
// -----------------------------------------------------------------------------
// signed_divider_if
// Request/result bundle of the signed divider.
//   in_valid, dividend, divisor         : request from master
//   in_ready                            : divider idle and accepting
//   out_valid                           : one-cycle result strobe
//   quotient, remainder, ovf, div_zero  : result, held until next out_valid
// Operands and results are two's-complement values carried as plain vectors.
// -----------------------------------------------------------------------------
interface signed_divider_if;
    import signed_div_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [DIVIDEND_W-1:0] dividend;
    logic [DIVISOR_W-1:0]  divisor;
    logic                  out_valid;
    logic [DIVISOR_W-1:0]  quotient;
    logic [DIVISOR_W-1:0]  remainder;
    logic                  ovf;
    logic                  div_zero;

    modport master (
        output in_valid, dividend, divisor,
        input  in_ready, out_valid, quotient, remainder, ovf, div_zero
    );

    modport slave (
        input  in_valid, dividend, divisor,
        output in_ready, out_valid, quotient, remainder, ovf, div_zero
    );

endinterface

// File: rtl/signed_divider_div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One restoring-division iteration (purely combinational).
//   partial     : {remainder, next dividend bit}, 17 bits
//   divisor_abs : |D|
//   rem_next    : partial - |D| if that does not go negative, else partial
//   q_bit       : 1 when the subtraction was taken
// -----------------------------------------------------------------------------
module div_step
    import signed_div_pkg::*;
(
    input  logic [DIVISOR_W:0]   partial,
    input  logic [DIVISOR_W-1:0] divisor_abs,
    output logic [DIVISOR_W-1:0] rem_next,
    output logic                 q_bit
);

    logic [DIVISOR_W-1:0] diff;

    // When the subtraction is taken the true difference is below |D|, so the
    // low 16 bits of the modular difference are exact.
    assign diff     = partial[DIVISOR_W-1:0] - divisor_abs;
    assign q_bit    = (partial >= {1'b0, divisor_abs});
    assign rem_next = q_bit ? diff : partial[DIVISOR_W-1:0];

endmodule

// File: rtl/signed_divider.sv
// -----------------------------------------------------------------------------
// signed_divider
// Sequential signed divider: 32-bit dividend / 16-bit divisor -> 16-bit
// quotient and remainder, restoring algorithm, one bit per cycle, fixed
// 17-cycle latency from accept to out_valid.
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active low
//   bus  : signed_divider_if.slave (request, result and flags)
// Quotient saturates to 0x7FFF / 0x8000 with ovf=1; divide by zero returns
// 0x7FFF / 0x8000 by dividend sign with div_zero=1.
// Build option ROUND_NEAREST_EN: round quotient half away from zero
// (remainder stays the truncated one).
// -----------------------------------------------------------------------------
module signed_divider
    import signed_div_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    signed_divider_if.slave bus
);

    state_t state, state_next;

    logic [DIVISOR_W-1:0] rem;      // partial remainder
    logic [DIVISOR_W-1:0] low;      // dividend low bits, shifted out as quotient shifts in
    logic [DIVISOR_W-1:0] d_abs;
    logic [3:0]           cnt;
    logic                 sign_q, sign_r, pre_ovf, dz;

    // Magnitudes of the incoming operands; 0x80000000 and 0x8000 map to themselves.
    logic [DIVIDEND_W-1:0] n_abs_in;
    logic [DIVISOR_W-1:0]  d_abs_in;
    logic                  pre_ovf_in;

    assign n_abs_in   = bus.dividend[DIVIDEND_W-1] ? (~bus.dividend + 32'd1) : bus.dividend;
    assign d_abs_in   = bus.divisor[DIVISOR_W-1]   ? (~bus.divisor + 16'd1)  : bus.divisor;
    // Upper half already >= |D| means the unsigned quotient needs 17+ bits.
    assign pre_ovf_in = (n_abs_in[DIVIDEND_W-1:DIVISOR_W] >= d_abs_in);

    assign bus.in_ready = (state == IDLE);

    // ---------------- controller ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.in_valid) state_next = CALC;
            CALC:    if (cnt == 4'd15) state_next = SIGN;
            SIGN:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- restoring step ----------------
    logic [DIVISOR_W-1:0] step_rem;
    logic                 step_q;

    div_step u_step (
        .partial     ({rem, low[DIVISOR_W-1]}),
        .divisor_abs (d_abs),
        .rem_next    (step_rem),
        .q_bit       (step_q)
    );

    // ---------------- sign / saturation ----------------
    logic [DIVISOR_W:0]   mag;      // one extra bit so a rounding carry is not lost
    logic                 sat;
    logic [DIVISOR_W-1:0] q_fin, r_fin;
    logic                 ovf_fin;

    always_comb begin
        mag = {1'b0, low};
`ifdef ROUND_NEAREST_EN
        if ({rem, 1'b0} >= {1'b0, d_abs}) mag = mag + 17'd1;
`endif
        sat     = pre_ovf || (sign_q ? (mag > 17'h08000) : (mag > 17'h07FFF));
        q_fin   = sign_q ? (~mag[DIVISOR_W-1:0] + 16'd1) : mag[DIVISOR_W-1:0];
        r_fin   = sign_r ? (~rem + 16'd1) : rem;
        ovf_fin = 1'b0;
        if (dz) begin
            q_fin = sign_r ? Q_MIN : Q_MAX;
            r_fin = '0;
        end else if (sat) begin
            q_fin   = sign_q ? Q_MIN : Q_MAX;
            r_fin   = '0;
            ovf_fin = 1'b1;
        end
    end

    // ---------------- datapath ----------------
    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: all of these are individual registers (no memory array), so all are reset; outputs must read 0 after an abort.
            rem           <= '0;
            low           <= '0;
            d_abs         <= '0;
            cnt           <= '0;
            sign_q        <= 1'b0;
            sign_r        <= 1'b0;
            pre_ovf       <= 1'b0;
            dz            <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.quotient  <= '0;
            bus.remainder <= '0;
            bus.ovf       <= 1'b0;
            bus.div_zero  <= 1'b0;
        end else begin
            bus.out_valid <= 1'b0;
            case (state)
                IDLE: if (bus.in_valid) begin
                    d_abs   <= d_abs_in;
                    sign_q  <= bus.dividend[DIVIDEND_W-1] ^ bus.divisor[DIVISOR_W-1];
                    sign_r  <= bus.dividend[DIVIDEND_W-1];
                    dz      <= (bus.divisor == '0);
                    pre_ovf <= pre_ovf_in;
                    rem     <= pre_ovf_in ? '0 : n_abs_in[DIVIDEND_W-1:DIVISOR_W];
                    low     <= n_abs_in[DIVISOR_W-1:0];
                    cnt     <= '0;
                end
                CALC: begin
                    rem <= step_rem;
                    low <= {low[DIVISOR_W-2:0], step_q};
                    cnt <= cnt + 4'd1;
                end
                SIGN: begin
                    bus.quotient  <= q_fin;
                    bus.remainder <= r_fin;
                    bus.ovf       <= ovf_fin;
                    bus.div_zero  <= dz;
                    bus.out_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
